// File: rtl/wb_dec_pkg.sv
// Shared definitions for the four-slave Wishbone address decoder:
// FSM state encodings, default slave address tags, canned response data.
package wb_dec_pkg;

    localparam int NUM_SLAVES = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_ACTIVE   = 2'd1;
    localparam state_t ST_UNMAPPED = 2'd2;
    localparam state_t ST_DONE     = 2'd3;

    localparam logic [7:0] DEF_SLAVE_0_ADDR = 8'h00;
    localparam logic [7:0] DEF_SLAVE_1_ADDR = 8'h01;
    localparam logic [7:0] DEF_SLAVE_2_ADDR = 8'h02;
    localparam logic [7:0] DEF_SLAVE_3_ADDR = 8'h03;

    localparam logic [31:0] UNMAPPED_DATA = 32'h0000_0000;
    localparam logic [31:0] TIMEOUT_DATA  = 32'hDEAD_DEAD;

    // Returns {hit, index}. Scanning from the top down lets the lowest
    // matching slave index win when two tags are configured identically.
    function automatic logic [2:0] decode_slave(input logic [7:0]  tag,
                                                input logic [31:0] addr_map);
        logic [2:0] res;
        res = 3'b000;
        for (int n = NUM_SLAVES - 1; n >= 0; n--) begin
            if (addr_map[n*8 +: 8] == tag) begin
                res = {1'b1, 2'(n)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_dec_timeout.sv
// Hung-cycle watchdog for the Wishbone decoder: counts strobe-without-ack
// cycles and flags expiry on the last count. Only built with WB_DEC_TIMEOUT_EN.
module wb_dec_timeout #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic count_en_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // A paused strobe holds the count; only an ack or leaving ACTIVE clears it.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_en_i) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = count_en_i && (count_q == LAST_COUNT);

endmodule

// File: rtl/wb_slave_decoder_4.sv
// Single-master, four-slave Wishbone decoder with self-answered unmapped
// accesses. Define WB_DEC_TIMEOUT_EN to force-terminate hung slave cycles.
module wb_slave_decoder_4
    import wb_dec_pkg::*;
#(
    parameter logic [7:0] SLAVE_0_ADDR   = DEF_SLAVE_0_ADDR,
    parameter logic [7:0] SLAVE_1_ADDR   = DEF_SLAVE_1_ADDR,
    parameter logic [7:0] SLAVE_2_ADDR   = DEF_SLAVE_2_ADDR,
    parameter logic [7:0] SLAVE_3_ADDR   = DEF_SLAVE_3_ADDR,
    parameter int         TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m_we_i,
    input  logic        m_cyc_i,
    input  logic        m_stb_i,
    input  logic [3:0]  m_sel_i,
    input  logic [31:0] m_adr_i,
    input  logic [31:0] m_dat_i,
    output logic        m_ack_o,
    output logic [31:0] m_dat_o,
    output logic        m_int_o,

    output logic        s0_we_o,
    output logic        s0_cyc_o,
    output logic        s0_stb_o,
    output logic [3:0]  s0_sel_o,
    output logic [31:0] s0_adr_o,
    output logic [31:0] s0_dat_o,
    input  logic        s0_ack_i,
    input  logic        s0_int_i,
    input  logic [31:0] s0_dat_i,

    output logic        s1_we_o,
    output logic        s1_cyc_o,
    output logic        s1_stb_o,
    output logic [3:0]  s1_sel_o,
    output logic [31:0] s1_adr_o,
    output logic [31:0] s1_dat_o,
    input  logic        s1_ack_i,
    input  logic        s1_int_i,
    input  logic [31:0] s1_dat_i,

    output logic        s2_we_o,
    output logic        s2_cyc_o,
    output logic        s2_stb_o,
    output logic [3:0]  s2_sel_o,
    output logic [31:0] s2_adr_o,
    output logic [31:0] s2_dat_o,
    input  logic        s2_ack_i,
    input  logic        s2_int_i,
    input  logic [31:0] s2_dat_i,

    output logic        s3_we_o,
    output logic        s3_cyc_o,
    output logic        s3_stb_o,
    output logic [3:0]  s3_sel_o,
    output logic [31:0] s3_adr_o,
    output logic [31:0] s3_dat_o,
    input  logic        s3_ack_i,
    input  logic        s3_int_i,
    input  logic [31:0] s3_dat_i,

    output logic [3:0]  int_src_o,
    output logic        unmapped_o,
    output logic        timeout_o
);

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  sel_q;
    logic [1:0]  sel_d;
    logic        ack_q;
    logic        ack_d;
    logic        unmapped_q;
    logic        unmapped_d;
    logic [3:0]  int_src_q;
    logic        m_int_q;

    logic [3:0]  s_ack;
    logic [3:0]  s_int;
    logic [31:0] s_dat [NUM_SLAVES];
    logic [3:0]  s_cyc;
    logic [3:0]  s_stb;

    logic        sel_ack;
    logic [31:0] sel_dat;
    logic        tmo_expire;
    logic        unm_ack;

    logic [2:0]  dec;
    logic        dec_hit;
    logic [1:0]  dec_idx;

    assign s_ack    = {s3_ack_i, s2_ack_i, s1_ack_i, s0_ack_i};
    assign s_int    = {s3_int_i, s2_int_i, s1_int_i, s0_int_i};
    assign s_dat[0] = s0_dat_i;
    assign s_dat[1] = s1_dat_i;
    assign s_dat[2] = s2_dat_i;
    assign s_dat[3] = s3_dat_i;

    // Strobes are gated by state alone, so an asynchronous reset that forces
    // IDLE drops every slave cyc/stb without waiting for a clock.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
            assign s_cyc[gi] = (state_q == ST_ACTIVE) && (sel_q == 2'(gi)) && m_cyc_i;
            assign s_stb[gi] = (state_q == ST_ACTIVE) && (sel_q == 2'(gi)) && m_stb_i;
        end
    endgenerate

    assign s0_cyc_o = s_cyc[0];
    assign s1_cyc_o = s_cyc[1];
    assign s2_cyc_o = s_cyc[2];
    assign s3_cyc_o = s_cyc[3];
    assign s0_stb_o = s_stb[0];
    assign s1_stb_o = s_stb[1];
    assign s2_stb_o = s_stb[2];
    assign s3_stb_o = s_stb[3];

    assign s0_we_o  = m_we_i;
    assign s1_we_o  = m_we_i;
    assign s2_we_o  = m_we_i;
    assign s3_we_o  = m_we_i;
    assign s0_sel_o = m_sel_i;
    assign s1_sel_o = m_sel_i;
    assign s2_sel_o = m_sel_i;
    assign s3_sel_o = m_sel_i;
    assign s0_adr_o = m_adr_i;
    assign s1_adr_o = m_adr_i;
    assign s2_adr_o = m_adr_i;
    assign s3_adr_o = m_adr_i;
    assign s0_dat_o = m_dat_i;
    assign s1_dat_o = m_dat_i;
    assign s2_dat_o = m_dat_i;
    assign s3_dat_o = m_dat_i;

    assign sel_ack = s_ack[sel_q];
    assign sel_dat = s_dat[sel_q];

    assign dec = decode_slave(m_adr_i[31:24],
                              {SLAVE_3_ADDR, SLAVE_2_ADDR, SLAVE_1_ADDR, SLAVE_0_ADDR});
    assign {dec_hit, dec_idx} = dec;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        unmapped_d = unmapped_q;
        case (state_q)
            ST_IDLE: begin
                if (m_cyc_i) begin
                    if (dec_hit) begin
                        state_d = ST_ACTIVE;
                        sel_d   = dec_idx;
                    end else begin
                        state_d    = ST_UNMAPPED;
                        unmapped_d = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                if (tmo_expire) begin
                    state_d = ST_DONE;
                end else if (!m_cyc_i && !sel_ack) begin
                    state_d = ST_IDLE;
                end
            end
            ST_UNMAPPED: begin
                if (!m_cyc_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (!m_cyc_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The first unmapped ack is launched from the missing decode in IDLE so it
    // lands one cycle after stb is sampled; it then alternates while stb holds.
    assign unm_ack = m_cyc_i && m_stb_i && !ack_q &&
                     (((state_q == ST_IDLE) && !dec_hit) || (state_q == ST_UNMAPPED));
    assign ack_d   = unm_ack || tmo_expire;

    always_comb begin
        m_ack_o = 1'b0;
        m_dat_o = UNMAPPED_DATA;
        case (state_q)
            ST_ACTIVE: begin
                m_ack_o = sel_ack;
                m_dat_o = sel_dat;
            end
            ST_UNMAPPED: begin
                m_ack_o = ack_q;
            end
            ST_DONE: begin
                m_ack_o = ack_q;
                m_dat_o = ack_q ? TIMEOUT_DATA : UNMAPPED_DATA;
            end
            default: begin
                m_ack_o = 1'b0;
                m_dat_o = UNMAPPED_DATA;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= 2'd0;
            ack_q      <= 1'b0;
            unmapped_q <= 1'b0;
            int_src_q  <= 4'd0;
            m_int_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            ack_q      <= ack_d;
            unmapped_q <= unmapped_d;
            int_src_q  <= s_int;
            m_int_q    <= |s_int;
        end
    end

    assign int_src_o  = int_src_q;
    assign m_int_o    = m_int_q;
    assign unmapped_o = unmapped_q;

`ifdef WB_DEC_TIMEOUT_EN
    logic sel_stb;
    logic timeout_q;

    assign sel_stb = s_stb[sel_q];

    wb_dec_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk        (clk),
        .rst_n      (rst_n),
        .count_en_i ((state_q == ST_ACTIVE) && sel_stb && !sel_ack),
        .clear_i    ((state_q != ST_ACTIVE) || sel_ack),
        .expire_o   (tmo_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else if (tmo_expire) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    // Keeps the timeout parameter referenced when the watchdog is compiled out.
    logic [15:0] timeout_cfg_unused;
    assign timeout_cfg_unused = 16'(TIMEOUT_CYCLES);
    assign tmo_expire         = 1'b0;
    assign timeout_o          = 1'b0;
`endif

endmodule

// File: tb/tb_wb_slave_decoder_4.sv
// Directed self-checking bench for wb_slave_decoder_4: slave routing, unmapped
// responses, interrupts, async reset, and the optional watchdog.
module tb_wb_slave_decoder_4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_we_i, m_cyc_i, m_stb_i;
    logic [3:0]  m_sel_i;
    logic [31:0] m_adr_i, m_dat_i;
    logic        m_ack_o;
    logic [31:0] m_dat_o;
    logic        m_int_o;

    logic        s0_we_o, s0_cyc_o, s0_stb_o, s0_ack_i, s0_int_i;
    logic        s1_we_o, s1_cyc_o, s1_stb_o, s1_ack_i, s1_int_i;
    logic        s2_we_o, s2_cyc_o, s2_stb_o, s2_ack_i, s2_int_i;
    logic        s3_we_o, s3_cyc_o, s3_stb_o, s3_ack_i, s3_int_i;
    logic [3:0]  s0_sel_o, s1_sel_o, s2_sel_o, s3_sel_o;
    logic [31:0] s0_adr_o, s1_adr_o, s2_adr_o, s3_adr_o;
    logic [31:0] s0_dat_o, s1_dat_o, s2_dat_o, s3_dat_o;
    logic [31:0] s0_dat_i, s1_dat_i, s2_dat_i, s3_dat_i;
    logic [3:0]  int_src_o;
    logic        unmapped_o, timeout_o;

    logic [3:0]  stb_vec, cyc_vec;
    int          checks = 0;
    int          errors = 0;

    assign stb_vec = {s3_stb_o, s2_stb_o, s1_stb_o, s0_stb_o};
    assign cyc_vec = {s3_cyc_o, s2_cyc_o, s1_cyc_o, s0_cyc_o};

    always #5 clk = ~clk;

    wb_slave_decoder_4 #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m_we_i     (m_we_i),
        .m_cyc_i    (m_cyc_i),
        .m_stb_i    (m_stb_i),
        .m_sel_i    (m_sel_i),
        .m_adr_i    (m_adr_i),
        .m_dat_i    (m_dat_i),
        .m_ack_o    (m_ack_o),
        .m_dat_o    (m_dat_o),
        .m_int_o    (m_int_o),
        .s0_we_o    (s0_we_o),
        .s0_cyc_o   (s0_cyc_o),
        .s0_stb_o   (s0_stb_o),
        .s0_sel_o   (s0_sel_o),
        .s0_adr_o   (s0_adr_o),
        .s0_dat_o   (s0_dat_o),
        .s0_ack_i   (s0_ack_i),
        .s0_int_i   (s0_int_i),
        .s0_dat_i   (s0_dat_i),
        .s1_we_o    (s1_we_o),
        .s1_cyc_o   (s1_cyc_o),
        .s1_stb_o   (s1_stb_o),
        .s1_sel_o   (s1_sel_o),
        .s1_adr_o   (s1_adr_o),
        .s1_dat_o   (s1_dat_o),
        .s1_ack_i   (s1_ack_i),
        .s1_int_i   (s1_int_i),
        .s1_dat_i   (s1_dat_i),
        .s2_we_o    (s2_we_o),
        .s2_cyc_o   (s2_cyc_o),
        .s2_stb_o   (s2_stb_o),
        .s2_sel_o   (s2_sel_o),
        .s2_adr_o   (s2_adr_o),
        .s2_dat_o   (s2_dat_o),
        .s2_ack_i   (s2_ack_i),
        .s2_int_i   (s2_int_i),
        .s2_dat_i   (s2_dat_i),
        .s3_we_o    (s3_we_o),
        .s3_cyc_o   (s3_cyc_o),
        .s3_stb_o   (s3_stb_o),
        .s3_sel_o   (s3_sel_o),
        .s3_adr_o   (s3_adr_o),
        .s3_dat_o   (s3_dat_o),
        .s3_ack_i   (s3_ack_i),
        .s3_int_i   (s3_int_i),
        .s3_dat_i   (s3_dat_i),
        .int_src_o  (int_src_o),
        .unmapped_o (unmapped_o),
        .timeout_o  (timeout_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        m_we_i  = 1'b0;  m_cyc_i = 1'b0;  m_stb_i = 1'b0;
        m_sel_i = 4'h0;  m_adr_i = 32'h0; m_dat_i = 32'h0;
        s0_ack_i = 1'b0; s1_ack_i = 1'b0; s2_ack_i = 1'b0; s3_ack_i = 1'b0;
        s0_int_i = 1'b0; s1_int_i = 1'b0; s2_int_i = 1'b0; s3_int_i = 1'b0;
        s0_dat_i = 32'h0; s1_dat_i = 32'h0; s2_dat_i = 32'h0; s3_dat_i = 32'h0;

        #3;
        chk("rst_cyc_vec", cyc_vec, 4'b0000);
        chk("rst_stb_vec", stb_vec, 4'b0000);
        chk("rst_m_ack", m_ack_o, 1'b0);
        chk("rst_m_dat", m_dat_o, 32'h0);
        chk("rst_m_int", m_int_o, 1'b0);
        chk("rst_int_src", int_src_o, 4'h0);
        chk("rst_unmapped", unmapped_o, 1'b0);
        chk("rst_timeout", timeout_o, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;

        // Write to slave 2, acked in the third strobed cycle.
        tick();
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b1; m_sel_i = 4'hF;
        m_adr_i = 32'h0200_0010; m_dat_i = 32'hA5A5_0001;
        #1;
        chk("t1_stb_latency", stb_vec, 4'b0000);
        chk("t1_s2_dat", s2_dat_o, 32'hA5A5_0001);
        tick();
        chk("t1_stb_vec", stb_vec, 4'b0100);
        chk("t1_cyc_vec", cyc_vec, 4'b0100);
        chk("t1_no_early_ack", m_ack_o, 1'b0);
        tick();
        tick();
        s2_ack_i = 1'b1;
        #1;
        chk("t1_ack", m_ack_o, 1'b1);
        chk("t1_s2_we", s2_we_o, 1'b1);
        tick();
        m_cyc_i = 1'b0; m_stb_i = 1'b0; s2_ack_i = 1'b0;
        #1;
        chk("t1_ack_single", m_ack_o, 1'b0);
        chk("t1_stb_drop", stb_vec, 4'b0000);

        // Read from slave 1, master restarts the cycle right after IDLE entry.
        tick();
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b0;
        m_adr_i = 32'h0100_0004; s1_dat_i = 32'h1234_5678;
        #1;
        chk("t2_stb_latency", stb_vec, 4'b0000);
        tick();
        m_adr_i = 32'h0300_0000;
        #1;
        chk("t2_no_redecode", stb_vec, 4'b0010);
        s1_ack_i = 1'b1;
        #1;
        chk("t2_ack", m_ack_o, 1'b1);
        chk("t2_rdata", m_dat_o, 32'h1234_5678);
        tick();
        m_cyc_i = 1'b0; m_stb_i = 1'b0; s1_ack_i = 1'b0;
        #1;
        chk("t2_ack_drop", m_ack_o, 1'b0);

        // Unmapped access, stb held to observe the alternating ack.
        tick();
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_adr_i = 32'h7F00_0000;
        #1;
        chk("t3_no_ack_yet", m_ack_o, 1'b0);
        chk("t3_unmapped_pre", unmapped_o, 1'b0);
        tick();
        chk("t3_ack", m_ack_o, 1'b1);
        chk("t3_rdata_zero", m_dat_o, 32'h0);
        chk("t3_unmapped_set", unmapped_o, 1'b1);
        chk("t3_no_slave_stb", stb_vec, 4'b0000);
        tick();
        chk("t3_ack_gap", m_ack_o, 1'b0);
        tick();
        chk("t3_ack_repeat", m_ack_o, 1'b1);
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        tick();
        chk("t3_ack_end", m_ack_o, 1'b0);
        chk("t3_unmapped_sticky", unmapped_o, 1'b1);

        // Interrupt sampling.
        s1_int_i = 1'b1; s3_int_i = 1'b1;
        #1;
        chk("t4_int_lag", int_src_o, 4'h0);
        tick();
        chk("t4_int_src", int_src_o, 4'b1010);
        chk("t4_m_int", m_int_o, 1'b1);
        s1_int_i = 1'b0; s3_int_i = 1'b0;
        tick();
        chk("t4_int_clear", int_src_o, 4'h0);
        chk("t4_m_int_clear", m_int_o, 1'b0);

        // Slave 3 never acks.
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_adr_i = 32'h0300_0000;
        tick();
        chk("t5_s3_stb", stb_vec, 4'b1000);
`ifdef WB_DEC_TIMEOUT_EN
        repeat (15) tick();
        chk("t5_no_early_ack", m_ack_o, 1'b0);
        chk("t5_no_early_timeout", timeout_o, 1'b0);
        tick();
        chk("t5_forced_ack", m_ack_o, 1'b1);
        chk("t5_dead_data", m_dat_o, 32'hDEAD_DEAD);
        chk("t5_timeout_flag", timeout_o, 1'b1);
        chk("t5_stb_low", stb_vec, 4'b0000);
        tick();
        chk("t5_ack_single", m_ack_o, 1'b0);
        chk("t5_done_hold", stb_vec, 4'b0000);
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        tick();
`else
        repeat (20) tick();
        chk("t5_still_waiting", m_ack_o, 1'b0);
        chk("t5_still_strobed", stb_vec, 4'b1000);
        chk("t5_timeout_tied", timeout_o, 1'b0);
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        tick();
`endif

        // Reset during a slave 0 cycle, then a clean slave 2 read.
        tick();
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b1; m_adr_i = 32'h0000_0040;
        tick();
        chk("t6_s0_cyc", cyc_vec, 4'b0001);
        rst_n = 1'b0;
        #1;
        chk("t6_cyc_async_drop", cyc_vec, 4'b0000);
        chk("t6_stb_async_drop", stb_vec, 4'b0000);
        chk("t6_no_ack", m_ack_o, 1'b0);
        chk("t6_m_dat", m_dat_o, 32'h0);
        chk("t6_unmapped_clr", unmapped_o, 1'b0);
        chk("t6_timeout_clr", timeout_o, 1'b0);
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b0;
        m_adr_i = 32'h0200_0000; s2_dat_i = 32'hCAFE_F00D;
        #1;
        chk("t6_stb_latency", stb_vec, 4'b0000);
        tick();
        chk("t6_s2_stb", stb_vec, 4'b0100);
        s2_ack_i = 1'b1;
        #1;
        chk("t6_ack", m_ack_o, 1'b1);
        chk("t6_rdata", m_dat_o, 32'hCAFE_F00D);
        tick();
        m_cyc_i = 1'b0; m_stb_i = 1'b0; s2_ack_i = 1'b0;
        tick();
        chk("t6_idle_ack", m_ack_o, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
